mem_seq: RTL and testbench

- Memory access sequencer that sits directly downstream of the memory pointer register.
- It takes the 16-bit address from the pointer's address-bus output and the 16-bit store data from the data bus.
- It performs word or byte loads/stores on a byte-wide external memory using a req/ack handshake with wait states and a timeout.
- It returns load data and done/err status to the CPU control unit.

---
 rtl/srp16_mem_pkg.sv | 14 +
 rtl/mem_wait_timer.sv | 27 ++
 rtl/mem_seq.sv | 144 ++++++++++++++
 tb/tb_mem_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/srp16_mem_pkg.sv
// Shared definitions for the memory access sequencer: state encoding,
// byte-lane width and the default wait-state timeout.
package srp16_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_t;

  localparam int BYTE_W          = 8;
  localparam int DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for one memory beat: synchronous clear, count enable,
// and a terminal-count flag when the count reaches TC_VAL.
module mem_wait_timer #(
  parameter logic [7:0] TC_VAL = 8'd254
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/mem_seq.sv
// Memory access sequencer: word/byte loads and stores over a byte-wide
// req/ack memory, little-endian, with a per-beat wait-state timeout.
module mem_seq
  import srp16_mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] abus_in,
  input  logic [DATA_W-1:0] dbus_in,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic              byte_mode,
  input  logic [BYTE_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [7:0] TC_VAL = 8'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              byte_q;
  logic              we_q;
  logic              beat_clr;
  logic              beat_en;
  logic              timeout;

  // The counter restarts whenever a beat begins or completes, and counts
  // only the cycles of an active beat that pass without an acknowledge.
  assign beat_clr = (state == ST_IDLE) || mem_ack;
  assign beat_en  = (state != ST_IDLE) && !mem_ack;

  mem_wait_timer #(
    .TC_VAL(TC_VAL)
  ) u_wait_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (beat_clr),
    .en   (beat_en),
    .tc   (timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      byte_q    <= 1'b0;
      we_q      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Store wins when both requests arrive together.
          if (wr_req || rd_req) begin
            addr_q    <= abus_in;
            data_q    <= dbus_in;
            byte_q    <= byte_mode;
            we_q      <= wr_req;
            mem_req   <= 1'b1;
            mem_we    <= wr_req;
            mem_addr  <= abus_in;
            mem_wdata <= dbus_in[BYTE_W-1:0];
            busy      <= 1'b1;
            state     <= ST_LO;
          end
        end
        ST_LO: begin
          if (mem_ack) begin
            if (!we_q) begin
              rdata[BYTE_W-1:0] <= mem_rdata;
            end
            if (byte_q) begin
              if (!we_q) begin
                rdata[DATA_W-1:BYTE_W] <= '0;
              end
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              mem_addr  <= addr_q + ADDR_W'(1);
              mem_wdata <= data_q[DATA_W-1:BYTE_W];
              state     <= ST_HI;
            end
          end else if (timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        ST_HI: begin
          if (mem_ack) begin
            if (!we_q) begin
              rdata[DATA_W-1:BYTE_W] <= mem_rdata;
            end
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_IDLE;
          end else if (timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_seq.sv
// Randomised scoreboard bench for mem_seq: a transaction-level memory model
// predicts beats and completions, a decoupled monitor checks them.
module tb_mem_seq;

  localparam int TC = 4;

  logic        clk;
  logic        reset;
  logic [15:0] abus_in;
  logic [15:0] dbus_in;
  logic        rd_req;
  logic        wr_req;
  logic        byte_mode;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [15:0] rdata;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } beat_t;

  typedef struct {
    logic        is_err;
    logic [15:0] rdata;
  } resp_t;

  beat_t       beat_q[$];
  resp_t       resp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] model_rdata;

  mem_seq #(
    .TIMEOUT_CYC(TC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .abus_in  (abus_in),
    .dbus_in  (dbus_in),
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .byte_mode(byte_mode),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic report_unexpected(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=present expected=none", name);
  endtask

  // Predicts the whole transaction from the access rules, then plays the
  // memory side with w wait cycles per beat (w >= TC means never ack).
  task automatic apply_stimulus(input bit wr, input bit rd, input bit bm,
                                input logic [15:0] a, input logic [15:0] d,
                                input int w0, input int w1,
                                input logic [7:0] r0, input logic [7:0] r1);
    int    nb;
    int    w;
    bit    to;
    beat_t eb;
    resp_t er;
    nb = bm ? 1 : 2;
    to = 1'b0;
    for (int b = 0; b < nb; b++) begin
      w = (b == 0) ? w0 : w1;
      if (w >= TC) begin
        to = 1'b1;
        break;
      end
      eb.addr  = a + 16'(b);
      eb.we    = wr;
      eb.wdata = (b == 0) ? d[7:0] : d[15:8];
      beat_q.push_back(eb);
      if (!wr) begin
        if (b == 0) model_rdata[7:0] = r0;
        else model_rdata[15:8] = r1;
      end
    end
    if (!to && !wr && bm) model_rdata[15:8] = 8'h00;
    er.is_err = to;
    er.rdata  = model_rdata;
    resp_q.push_back(er);

    @(negedge clk);
    wr_req    = wr;
    rd_req    = rd;
    abus_in   = a;
    dbus_in   = d;
    byte_mode = bm;
    mem_ack   = 1'b0;
    @(posedge clk);
    for (int b = 0; b < nb; b++) begin
      w = (b == 0) ? w0 : w1;
      for (int k = 0; k < TC; k++) begin
        @(negedge clk);
        check_output("busy_req_active", {busy, mem_req}, 2'b11);
        rd_req    = 1'($urandom_range(0, 1));
        wr_req    = 1'($urandom_range(0, 1));
        abus_in   = 16'($urandom);
        dbus_in   = 16'($urandom);
        byte_mode = 1'($urandom_range(0, 1));
        mem_ack   = (k == w);
        mem_rdata = (k == w) ? ((b == 0) ? r0 : r1) : 8'($urandom);
        @(posedge clk);
        if (k == w) break;
      end
      if (w >= TC) break;
    end
    @(negedge clk);
    check_output("end_done", done, !to);
    check_output("end_err", err, to);
    check_output("end_idle", {mem_req, mem_we, busy}, 3'b000);
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    mem_ack = 1'b0;
  endtask

  // Scoreboard monitor: checks every acknowledged beat and every completion.
  always begin
    beat_t xb;
    resp_t xr;
    @(negedge clk);
    #1;
    if (!reset) begin
      if (mem_req && mem_ack) begin
        if (beat_q.size() == 0) begin
          report_unexpected("beat_unexpected");
        end else begin
          xb = beat_q.pop_front();
          check_output("beat_addr", mem_addr, xb.addr);
          check_output("beat_we", mem_we, xb.we);
          check_output("beat_wdata", mem_wdata, xb.wdata);
        end
      end
      if (done || err) begin
        if (resp_q.size() == 0) begin
          report_unexpected("resp_unexpected");
        end else begin
          xr = resp_q.pop_front();
          check_output("resp_err", err, xr.is_err);
          check_output("resp_done", done, !xr.is_err);
          check_output("resp_rdata", rdata, xr.rdata);
        end
      end
    end
  end

  initial begin
    beat_t eb;
    resp_t er;
    logic [15:0] ra;
    model_rdata = 16'h0000;

    // Reset held with a pending byte load and ack high.
    reset     = 1'b1;
    rd_req    = 1'b1;
    wr_req    = 1'b0;
    mem_ack   = 1'b1;
    byte_mode = 1'b1;
    abus_in   = 16'h0003;
    dbus_in   = 16'hBEEF;
    mem_rdata = 8'hC7;
    repeat (2) @(negedge clk);
    check_output("reset_outputs", {mem_req, mem_we, busy, done, err, mem_addr, mem_wdata, rdata}, 64'h0);
    eb.addr = 16'h0003; eb.we = 1'b0; eb.wdata = 8'hEF;
    beat_q.push_back(eb);
    model_rdata = 16'h00C7;
    er.is_err = 1'b0; er.rdata = model_rdata;
    resp_q.push_back(er);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output("first_access_started", {mem_req, busy, done}, 3'b110);
    check_output("first_access_addr", mem_addr, 16'h0003);
    rd_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output("byte_done_edge1", done, 1'b1);
    mem_ack = 1'b0;

    // Directed cases.
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0F0F, 16'hA55A, 0, 0, 8'h00, 8'h00);
    check_output("store_keeps_rdata", rdata, 16'h00C7);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 2, 2, 8'h34, 8'h12);
    check_output("word_load_ffff", rdata, 16'h1234);
    apply_stimulus(1'b0, 1'b1, 1'b1, 16'h0003, 16'h1111, 0, 0, 8'hC7, 8'h99);
    check_output("byte_load_zext", rdata, 16'h00C7);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h2000, 16'h0000, TC, 0, 8'h77, 8'h88);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h2000, 16'h0000, TC - 1, 1, 8'h77, 8'h88);
    check_output("ack_on_timeout_edge", rdata, 16'h8877);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h3000, 16'h0000, 0, TC, 8'h5E, 8'hAA);
    check_output("timeout_keeps_lo", rdata, 16'h885E);
    apply_stimulus(1'b1, 1'b1, 1'b0, 16'h4000, 16'hC33C, 1, 0, 8'hFF, 8'hFF);
    check_output("both_req_store", rdata, 16'h885E);

    // Reset asserted during the high beat of a word load.
    eb.addr = 16'h5000; eb.we = 1'b0; eb.wdata = 8'h21;
    beat_q.push_back(eb);
    @(negedge clk);
    rd_req = 1'b1; abus_in = 16'h5000; dbus_in = 16'h4321; byte_mode = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h66;
    @(posedge clk);
    @(negedge clk);
    check_output("hi_beat_addr", mem_addr, 16'h5001);
    mem_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_output("reset_mid_hi_req", {mem_req, busy}, 2'b00);
    @(negedge clk);
    check_output("reset_mid_hi_quiet", {done, err, rdata}, 18'h0);
    reset = 1'b0;
    model_rdata = 16'h0000;

    // Randomised traffic with idle gaps carrying stray acks.
    for (int t = 0; t < 80; t++) begin
      ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      apply_stimulus(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), ra, 16'($urandom),
                     $urandom_range(0, TC), $urandom_range(0, TC),
                     8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = 8'($urandom);
      end
    end

    repeat (5) @(negedge clk);
    check_output("beat_queue_drained", beat_q.size(), 0);
    check_output("resp_queue_drained", resp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
